// File: rtl/legv8_control_fsm.sv
// LEGv8 multicycle control unit.
// Each instruction takes two cycles. FETCH latches the ROM word into IR.
// EXECUTE decodes IR into the datapath ControlWord, the constant K, the PC
// select and the status-load enable. An undecoded opcode either parks the
// unit in HALT or executes as a NOP, depending on HALT_ON_ILLEGAL.
// Every output is a combinational function of the state register and IR, so
// an asserted reset forces the all-zero/hold output set at once.
module legv8_control_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [4:0]  status,
    output logic [24:0] ControlWord,
    output logic [63:0] K,
    output logic [1:0]  PS,
    output logic        SL,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_HALT    = 2'b10
    } state_t;

    // ALU function select: {op[2:0], invA, invB_cin}
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_REL  = 2'b10;
    localparam logic [1:0] PS_BUS  = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;

    // Decoded EXECUTE-cycle fields
    logic [4:0]  sa_s, sb_s, da_s, fs_s;
    logic        reg_write_s, mem_write_s, bsel_s, en_mem_s, en_alu_s;
    logic [63:0] k_s;
    logic [1:0]  ps_s;
    logic        sl_s;
    logic        illegal_s;

    // Instruction fields
    logic [4:0]  rd_s, rn_s, rm_s;
    logic [63:0] k_cb_s;

    assign rd_s   = ir_q[4:0];
    assign rn_s   = ir_q[9:5];
    assign rm_s   = ir_q[20:16];
    assign k_cb_s = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};

    // B.cond evaluation against the registered flags {V,C,N,Z}; codes without
    // a listed condition are never taken.
    function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] vcnz);
        logic v, c, n, z;
        logic taken;
        v = vcnz[3];
        c = vcnz[2];
        n = vcnz[1];
        z = vcnz[0];
        case (cond)
            4'h0:    taken = z;
            4'h1:    taken = !z;
            4'h2:    taken = c;
            4'h3:    taken = !c;
            4'hA:    taken = (n == v);
            4'hB:    taken = (n != v);
            4'hC:    taken = !z && (n == v);
            4'hD:    taken = z || (n != v);
            4'hE:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // State and instruction register with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ir_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic and IR load
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = instruction;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (illegal_s && HALT_ON_ILLEGAL) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Instruction decode of IR into the EXECUTE-cycle control set
    always_comb begin
        sa_s        = 5'd0;
        sb_s        = 5'd0;
        da_s        = 5'd0;
        fs_s        = FS_AND;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        bsel_s      = 1'b0;
        en_mem_s    = 1'b0;
        en_alu_s    = 1'b0;
        k_s         = 64'd0;
        ps_s        = PS_INC;
        sl_s        = 1'b0;
        illegal_s   = 1'b0;
        casez (ir_q[31:21])
            // Register-register ALU ops
            11'b10001011000, 11'b10101011000, 11'b11001011000, 11'b11101011000,
            11'b10001010000, 11'b11101010000, 11'b10101010000, 11'b11001010000: begin
                sa_s        = rn_s;
                sb_s        = rm_s;
                da_s        = rd_s;
                reg_write_s = 1'b1;
                en_alu_s    = 1'b1;
                case (ir_q[31:21])
                    11'b10001011000: fs_s = FS_ADD;
                    11'b10101011000: begin fs_s = FS_ADD; sl_s = 1'b1; end
                    11'b11001011000: fs_s = FS_SUB;
                    11'b11101011000: begin fs_s = FS_SUB; sl_s = 1'b1; end
                    11'b10001010000: fs_s = FS_AND;
                    11'b11101010000: begin fs_s = FS_AND; sl_s = 1'b1; end
                    11'b10101010000: fs_s = FS_OR;
                    default:         fs_s = FS_XOR;
                endcase
            end
            // Immediate ALU ops: 12-bit zero-extended constant on the B side
            11'b1001000100?, 11'b1101000100?, 11'b1001001000?,
            11'b1011001000?, 11'b1101001000?: begin
                sa_s        = rn_s;
                sb_s        = rm_s;
                da_s        = rd_s;
                reg_write_s = 1'b1;
                en_alu_s    = 1'b1;
                bsel_s      = 1'b1;
                k_s         = {52'd0, ir_q[21:10]};
                case (ir_q[31:22])
                    10'b1001000100: fs_s = FS_ADD;
                    10'b1101000100: fs_s = FS_SUB;
                    10'b1001001000: fs_s = FS_AND;
                    10'b1011001000: fs_s = FS_OR;
                    default:        fs_s = FS_XOR;
                endcase
            end
            // Shifts by the 6-bit shamt
            11'b11010011011, 11'b11010011010: begin
                sa_s        = rn_s;
                sb_s        = rm_s;
                da_s        = rd_s;
                reg_write_s = 1'b1;
                en_alu_s    = 1'b1;
                bsel_s      = 1'b1;
                k_s         = {58'd0, ir_q[15:10]};
                if (ir_q[21]) begin
                    fs_s = FS_LSL;
                end else begin
                    fs_s = FS_LSR;
                end
            end
            // LDUR: memory drives the bus, ALU forms the address only
            11'b11111000010: begin
                sa_s        = rn_s;
                da_s        = rd_s;
                k_s         = {{55{ir_q[20]}}, ir_q[20:12]};
                bsel_s      = 1'b1;
                fs_s        = FS_ADD;
                reg_write_s = 1'b1;
                en_mem_s    = 1'b1;
            end
            // STUR: Rt is read through the B port as store data
            11'b11111000000: begin
                sa_s        = rn_s;
                sb_s        = rd_s;
                k_s         = {{55{ir_q[20]}}, ir_q[20:12]};
                bsel_s      = 1'b1;
                fs_s        = FS_ADD;
                mem_write_s = 1'b1;
            end
            // BR: Rn is routed through the ALU (OR with XZR) onto the bus
            11'b11010110000: begin
                sa_s     = rn_s;
                sb_s     = 5'd31;
                fs_s     = FS_OR;
                en_alu_s = 1'b1;
                ps_s     = PS_BUS;
            end
            // CBZ / CBNZ: XZR | Rt produces the live zero flag on status[0]
            11'b10110100???, 11'b10110101???: begin
                sa_s = 5'd31;
                sb_s = rd_s;
                fs_s = FS_OR;
                k_s  = k_cb_s;
                if (status[0] != ir_q[24]) begin
                    ps_s = PS_REL;
                end else begin
                    ps_s = PS_INC;
                end
            end
            // B.cond on the registered flags
            11'b01010100???: begin
                k_s = k_cb_s;
                if (cond_taken(ir_q[3:0], status[4:1])) begin
                    ps_s = PS_REL;
                end else begin
                    ps_s = PS_INC;
                end
            end
            // B: unconditional PC-relative
            11'b000101?????: begin
                k_s  = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};
                ps_s = PS_REL;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Output select: decoded set only in EXECUTE, all-zero/hold otherwise
    always_comb begin
        ControlWord = 25'd0;
        K           = 64'd0;
        PS          = PS_HOLD;
        SL          = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_EXECUTE: begin
                ControlWord = {sa_s, sb_s, da_s, reg_write_s, mem_write_s,
                               fs_s, bsel_s, en_mem_s, en_alu_s};
                K           = k_s;
                PS          = ps_s;
                SL          = sl_s;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_FETCH: begin
                halted = 1'b0;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_legv8_control_fsm.sv
// Directed self-checking bench for legv8_control_fsm.
module tb_legv8_control_fsm;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic [4:0]  status;
    logic [24:0] ControlWord;
    logic [63:0] K;
    logic [1:0]  PS;
    logic        SL;
    logic        halted;

    int checks = 0;
    int errors = 0;

    legv8_control_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .status      (status),
        .ControlWord (ControlWord),
        .K           (K),
        .PS          (PS),
        .SL          (SL),
        .halted      (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected ControlWord packing
    function automatic logic [24:0] cw(input logic [4:0] sa, input logic [4:0] sb,
                                       input logic [4:0] da, input logic rw, input logic mw,
                                       input logic [4:0] fs, input logic bs,
                                       input logic em, input logic ea);
        return {sa, sb, da, rw, mw, fs, bs, em, ea};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word during FETCH and stop at the middle of its EXECUTE cycle
    task automatic fetch_exec(input logic [31:0] instr);
        instruction = instr;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_exec(input string tag, input logic [24:0] exp_cw,
                              input logic [63:0] exp_k, input logic [1:0] exp_ps,
                              input logic exp_sl);
        check({tag, ".cw"}, 64'(ControlWord), 64'(exp_cw));
        check({tag, ".k"},  K, exp_k);
        check({tag, ".ps"}, 64'(PS), 64'(exp_ps));
        check({tag, ".sl"}, 64'(SL), 64'(exp_sl));
        check({tag, ".halted"}, 64'(halted), 64'd0);
        check({tag, ".bus"}, 64'(ControlWord[1] & ControlWord[0]), 64'd0);
    endtask

    task automatic check_idle(input string tag, input logic exp_halted);
        check({tag, ".cw"}, 64'(ControlWord), 64'd0);
        check({tag, ".k"},  K, 64'd0);
        check({tag, ".ps"}, 64'(PS), 64'd0);
        check({tag, ".sl"}, 64'(SL), 64'd0);
        check({tag, ".halted"}, 64'(halted), 64'(exp_halted));
    endtask

    initial begin
        reset       = 1'b1;
        instruction = 32'h8B030041;
        status      = 5'b00000;
        @(posedge clock);
        @(negedge clock);
        check_idle("reset", 1'b0);

        // ADD X1,X2,X3 then reset mid-EXECUTE
        reset = 1'b0;
        fetch_exec(32'h8B030041);
        check_exec("add", cw(5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b1),
                   64'd0, 2'b01, 1'b0);
        reset = 1'b1;
        #1;
        check_idle("reset_mid_exec", 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // First edge after release must latch the word (FETCH)
        fetch_exec(32'hAB030041);
        check_exec("adds", cw(5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b1),
                   64'd0, 2'b01, 1'b1);
        next_cycle();
        check_idle("fetch_after_adds", 1'b0);

        // SUB X7,X8,X9
        fetch_exec(32'hCB090107);
        check_exec("sub", cw(5'd8, 5'd9, 5'd7, 1'b1, 1'b0, 5'b01001, 1'b0, 1'b0, 1'b1),
                   64'd0, 2'b01, 1'b0);
        next_cycle();

        // ANDS X1,X2,X3
        fetch_exec(32'hEA030041);
        check_exec("ands", cw(5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1),
                   64'd0, 2'b01, 1'b1);
        next_cycle();

        // ADDI X10,X11,#0xFFF: largest immediate, zero-extended
        fetch_exec(32'h913FFD6A);
        check_exec("addi", cw(5'd11, 5'd31, 5'd10, 1'b1, 1'b0, 5'b01000, 1'b1, 1'b0, 1'b1),
                   64'h0000_0000_0000_0FFF, 2'b01, 1'b0);
        next_cycle();

        // LSR X2,X3,#5
        fetch_exec(32'hD3401462);
        check_exec("lsr", cw(5'd3, 5'd0, 5'd2, 1'b1, 1'b0, 5'b10100, 1'b1, 1'b0, 1'b1),
                   64'd5, 2'b01, 1'b0);
        next_cycle();

        // LDUR X5,[X6,#-8]
        fetch_exec(32'hF85F80C5);
        check_exec("ldur", cw(5'd6, 5'd0, 5'd5, 1'b1, 1'b0, 5'b01000, 1'b1, 1'b1, 1'b0),
                   64'hFFFF_FFFF_FFFF_FFF8, 2'b01, 1'b0);
        next_cycle();

        // STUR X5,[X6,#-8]
        fetch_exec(32'hF81F80C5);
        check_exec("stur", cw(5'd6, 5'd5, 5'd0, 1'b0, 1'b1, 5'b01000, 1'b1, 1'b0, 1'b0),
                   64'hFFFF_FFFF_FFFF_FFF8, 2'b01, 1'b0);
        next_cycle();

        // CBZ X4,#+3 words: taken on live Z, then not taken
        status = 5'b00001;
        fetch_exec(32'hB4000064);
        check_exec("cbz_taken", cw(5'd31, 5'd4, 5'd0, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b0, 1'b0),
                   64'd12, 2'b10, 1'b0);
        status = 5'b00000;
        #1;
        check("cbz_not_taken.ps", 64'(PS), 64'd1);
        next_cycle();

        // CBNZ X4,#+3 words with live Z clear
        fetch_exec(32'hB5000064);
        check("cbnz_taken.ps", 64'(PS), 64'd2);
        check("cbnz_taken.k", K, 64'd12);
        next_cycle();

        // B.GT #+2 words: flags all clear -> taken; Z=1 -> not taken
        status = 5'b00000;
        fetch_exec(32'h5400004C);
        check_exec("bgt_taken", 25'd0, 64'd8, 2'b10, 1'b0);
        status = 5'b00010;
        #1;
        check("bgt_not_taken.ps", 64'(PS), 64'd1);
        next_cycle();

        // B.LT with N=1, V=0 -> taken; an unlisted code (MI) never taken
        status = 5'b00100;
        fetch_exec(32'h5400004B);
        check("blt_taken.ps", 64'(PS), 64'd2);
        next_cycle();
        fetch_exec(32'h54000044);
        check("bmi_never.ps", 64'(PS), 64'd1);
        next_cycle();
        status = 5'b00000;

        // B #-1 word: negative sign extension
        fetch_exec(32'h17FFFFFF);
        check_exec("b_back", 25'd0, 64'hFFFF_FFFF_FFFF_FFFC, 2'b10, 1'b0);
        next_cycle();

        // BR X30
        fetch_exec(32'hD61F03C0);
        check_exec("br", cw(5'd30, 5'd31, 5'd0, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b0, 1'b1),
                   64'd0, 2'b11, 1'b0);
        next_cycle();

        // Illegal all-zero word -> HALT, held for 10 cycles
        fetch_exec(32'h00000000);
        check("illegal_exec.cw", 64'(ControlWord), 64'd0);
        check("illegal_exec.halted", 64'(halted), 64'd0);
        instruction = 32'h8B030041;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            check_idle($sformatf("halt%0d", i), 1'b1);
        end

        // Only reset leaves HALT
        reset = 1'b1;
        #1;
        check_idle("halt_reset", 1'b0);
        @(negedge clock);
        reset = 1'b0;
        fetch_exec(32'hAB030041);
        check_exec("adds_after_halt", cw(5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b1),
                   64'd0, 2'b01, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
